// File: rtl/inv_serial_arbiter.sv
// Round-robin two-requester front end for the shared 1-bit inverter; optional INV_SEQ_PARALLEL_EN build.
// Latency: WIDTH cycles from acceptance to out_valid (1 cycle with INV_SEQ_PARALLEL_EN defined).
// Backpressure: result held in HOLD until out_ready; req*_ready low whenever a word is in flight.
module inv_serial_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             grant0, grant1;
    logic             accept;

    // On a tie the requester not served last wins; last_grant_q resets to 1.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

`ifdef INV_SEQ_PARALLEL_EN
    logic [WIDTH-1:0] par_inv;
    assign par_inv = ~shift_q;
`else
    logic inv_in, inv_out;
    assign inv_in  = shift_q[0];
    assign inv_out = ~inv_in;   // the single time-shared inverter cell
`endif

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        res_d        = res_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d      = req1_ready ? req1_data : req0_data;
                    id_d         = req1_ready;
                    last_grant_d = req1_ready;
                    cnt_d        = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
`ifdef INV_SEQ_PARALLEL_EN
                res_d   = par_inv;
                state_d = HOLD;
`else
                // Result fills from the MSB so the LSB-first stream lands in place.
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = inv_out;
                shift_d          = shift_q >> 1;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = HOLD;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            res_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            res_q        <= res_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_data  = res_q;
    assign out_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_inv_serial_arbiter.sv
// Directed bench for inv_serial_arbiter: reset, single request, round-robin, backpressure, mid-op reset.
module tb_inv_serial_arbiter;

    localparam int WIDTH = 8;
`ifdef INV_SEQ_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             out_ready;
    logic             busy;

    int               tests = 0;
    int               fails = 0;
    int               n_ev;
    int               lat_cnt;
    int               ev_cyc [3];
    logic [WIDTH-1:0] ev_dat [3];
    logic             ev_id  [3];

    inv_serial_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both requesters valid and random data
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = WIDTH'($urandom);
        req1_data  = WIDTH'($urandom);
        out_ready  = 1'($urandom_range(0, 1));
        repeat (3) tick();
        check("rst_out_valid",  32'(out_valid),  32'h0);
        check("rst_out_data",   32'(out_data),   32'h0);
        check("rst_out_id",     32'(out_id),     32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_req0_ready", 32'(req0_ready), 32'h1);
        check("rst_req1_ready", 32'(req1_ready), 32'h0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        rst_n      = 1'b1;
        repeat (3) begin
            tick();
            check("post_rst_no_out", 32'(out_valid), 32'h0);
        end

        // Single request from requester 0
        req0_data  = 8'hA5;
        req0_valid = 1'b1;
        #1;
        check("single_req0_ready", 32'(req0_ready), 32'h1);
        check("single_req1_ready", 32'(req1_ready), 32'h0);
        tick();
        req0_valid = 1'b0;
        req0_data  = 8'hFF;
        #1;
        check("single_busy", 32'(busy), 32'h1);
        for (int i = 0; i < LAT; i++) begin
            check("single_early_valid", 32'(out_valid),  32'h0);
            check("single_req1_low",    32'(req1_ready), 32'h0);
            tick();
        end
        check("single_out_valid", 32'(out_valid), 32'h1);
        check("single_out_data",  32'(out_data),  32'h5A);
        check("single_out_id",    32'(out_id),    32'h0);
        tick();
        check("single_done_valid", 32'(out_valid), 32'h0);
        check("single_done_busy",  32'(busy),      32'h0);

        // Round-robin from a fresh reset so requester 0 wins the first tie
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ev_cyc[k] = -1;
            ev_dat[k] = '0;
            ev_id[k]  = 1'b0;
        end
        req0_data  = 8'h0F;
        req1_data  = 8'hF0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        out_ready  = 1'b1;
        n_ev       = 0;
        for (int c = 1; c <= 3 * (LAT + 2); c++) begin
            tick();
            if (out_valid) begin
                if (n_ev < 3) begin
                    ev_cyc[n_ev] = c;
                    ev_dat[n_ev] = out_data;
                    ev_id[n_ev]  = out_id;
                end
                n_ev++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_count", 32'(n_ev), 32'd3);
        check("rr0_cyc",  32'(ev_cyc[0]), 32'(1 + LAT));
        check("rr0_data", 32'(ev_dat[0]), 32'hF0);
        check("rr0_id",   32'(ev_id[0]),  32'h0);
        check("rr1_cyc",  32'(ev_cyc[1]), 32'(1 + LAT + (LAT + 2)));
        check("rr1_data", 32'(ev_dat[1]), 32'h0F);
        check("rr1_id",   32'(ev_id[1]),  32'h1);
        check("rr2_cyc",  32'(ev_cyc[2]), 32'(1 + LAT + 2 * (LAT + 2)));
        check("rr2_data", 32'(ev_dat[2]), 32'hF0);
        check("rr2_id",   32'(ev_id[2]),  32'h0);

        // Backpressure: result held while out_ready low, competing requests stalled
        out_ready  = 1'b0;
        req1_data  = 8'h3C;
        req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        repeat (LAT) tick();
        check("bp_out_valid", 32'(out_valid), 32'h1);
        req0_data  = 8'h55;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold_valid", 32'(out_valid),  32'h1);
            check("bp_hold_data",  32'(out_data),   32'hC3);
            check("bp_hold_id",    32'(out_id),     32'h1);
            check("bp_hold_busy",  32'(busy),       32'h1);
            check("bp_req0_ready", 32'(req0_ready), 32'h0);
            check("bp_req1_ready", 32'(req1_ready), 32'h0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_valid", 32'(out_valid), 32'h1);
        tick();
        check("bp_idle_valid", 32'(out_valid), 32'h0);
        check("bp_idle_busy",  32'(busy),      32'h0);
        check("bp_idle_req0",  32'(req0_ready), 32'h1);
        check("bp_idle_req1",  32'(req1_ready), 32'h0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("bp_next_accept_busy", 32'(busy), 32'h1);
        repeat (LAT) tick();
        check("bp_next_valid", 32'(out_valid), 32'h1);
        check("bp_next_data",  32'(out_data),  32'hAA);
        check("bp_next_id",    32'(out_id),    32'h0);
        tick();

        // Asynchronous reset in the middle of a word
        out_ready  = 1'b0;
        req0_data  = 8'h77;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_busy",      32'(busy),      32'h0);
        check("rstmid_out_valid", 32'(out_valid), 32'h0);
        check("rstmid_out_data",  32'(out_data),  32'h0);
        check("rstmid_out_id",    32'(out_id),    32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstmid_no_emit", 32'(out_valid), 32'h0);
        out_ready  = 1'b1;
        req0_data  = 8'h33;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        lat_cnt = 0;
        while (!out_valid && lat_cnt < 40) begin
            tick();
            lat_cnt++;
        end
        check("rstmid_latency", 32'(lat_cnt),  32'(LAT));
        check("rstmid_data",    32'(out_data), 32'hCC);
        check("rstmid_id",      32'(out_id),   32'h0);
        tick();

        // Requester 1 word with a pattern touching both ends
        req1_data  = 8'h81;
        req1_valid = 1'b1;
        #1;
        check("r1_req1_ready", 32'(req1_ready), 32'h1);
        tick();
        req1_valid = 1'b0;
        lat_cnt = 0;
        while (!out_valid && lat_cnt < 40) begin
            tick();
            lat_cnt++;
        end
        check("r1_latency", 32'(lat_cnt),  32'(LAT));
        check("r1_data",    32'(out_data), 32'h7E);
        check("r1_id",      32'(out_id),   32'h1);
        tick();
        check("r1_done_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inv_serial_arbiter.md
# inv_serial_arbiter

Two-requester arbiter and sequencer for the team's shared 1-bit inverter cell (`myNOT`). The block accepts a WIDTH-bit word from one of two requesters using round-robin arbitration. It streams the word LSB-first through the single shared inverter, one bit per clock. It then presents the fully inverted word with the requester's ID on a valid/ready output port. It sits between requester logic and downstream consumers wherever one inverter cell is time-shared instead of instantiating WIDTH copies.

## Interface
- WIDTH, default 8: data word width; legal range 1..32.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a word
- req0_data  input  WIDTH  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle when high with req0_valid
- req1_valid  input  1  requester 1 has a word
- req1_data  input  WIDTH  requester 1 word
- req1_ready  output  1  requester 1 word accepted this cycle when high with req1_valid
- out_valid  output  1  inverted result available
- out_data  output  WIDTH  bitwise inverse of accepted word
- out_id  output  1  index of requester whose word is in out_data
- out_ready  input  1  downstream consumes result when high with out_valid
- busy  output  1  high in SHIFT or HOLD

## Operation
- One clock (clk); reset is asynchronous, active-low (rst_n).
- FSM states:
  - IDLE: no word in flight.
  - SHIFT: inverter cell in use.
  - HOLD: result presented.
- IDLE behaviour:
  - Grant goes to the only valid requester.
  - If both requesters are valid, grant goes to the one not granted last.
  - reqN_ready = 1 only for the granted requester, combinationally from the valids.
  - On acceptance (valid & ready): load shift register with data; record out_id; clear bit counter; update last_grant; go to SHIFT.
- SHIFT behaviour:
  - Each cycle, shift_reg[0] drives the shared inverter.
  - Inverter output shifts into the MSB of the result register, which shifts right.
  - Shift register shifts right.
  - Counter increments; after WIDTH SHIFT cycles go to HOLD.
- HOLD behaviour: out_valid = 1; out_data and out_id held stable until out_ready.
- Leaving HOLD:
  - On out_valid & out_ready, go to IDLE.
  - No new word is accepted in that same cycle.
- Both reqN_ready are 0 in SHIFT and HOLD. Requester data need only be valid in the acceptance cycle.
- Counter width: clog2(WIDTH+1) bits. No wrap-around; it saturates via the state transition.

## Timing
- Reset values:
  - state IDLE; out_valid 0; out_data 0; out_id 0; busy 0.
  - last_grant 1, so requester 0 wins the first tie.
  - reqN_ready follow the IDLE grant rule immediately after reset.
- Reset asserted mid-SHIFT or mid-HOLD: word is discarded and all registers return to reset values asynchronously; nothing is emitted.
- Latency: acceptance at edge E0 → out_valid high after edge E0+WIDTH (serial build).
- Minimum spacing between acceptances is WIDTH+2 cycles with out_ready tied high.
- out_ready high while out_valid is low has no effect.
- Request valids may drop while not granted; no state is kept for a dropped request.

## Configuration
- INV_SEQ_PARALLEL_EN defined:
  - SHIFT lasts exactly 1 cycle.
  - out_data is loaded with ~word using WIDTH parallel inverters.
  - Latency = 1 cycle (out_valid high after edge E0+1).
  - Arbitration and handshakes are unchanged.
- Undefined (default): bit-serial through the single shared inverter as described above; latency WIDTH.

## Test plan
- Reset: hold rst_n=0 with random inputs → out_valid=0, out_data=0x00, busy=0, req0_ready=1 when both valid; release → no spurious output.
- Single request (WIDTH=8): req0_data=0xA5, req0_valid for one cycle → out_valid rises exactly 8 cycles later with out_data=0x5A, out_id=0; req1_ready=0 throughout.
- Round-robin: both requesters continuously valid (req0=0x0F, req1=0xF0), out_ready=1 → outputs alternate 0xF0/id0, 0x0F/id1, 0xF0/id0, spaced 10 cycles apart.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_data/out_id stable, both reqN_ready=0, busy=1; out_ready=1 → IDLE the next cycle, acceptance no earlier than the following cycle.
- Reset mid-operation: rst_n pulsed low at SHIFT cycle 4 → immediate return to reset values; the next request 0x33 → 0xCC with full 8-cycle latency.
- Macro build with INV_SEQ_PARALLEL_EN: req1_data=0x81 → out_valid 1 cycle after acceptance, out_data=0x7E, out_id=1.
